fifo_drain_ctrl: RTL

Sequencer that automatically empties a Wishbone FIFO pop port into a byte-stream consumer, such as the UART transmitter. While enabled and the FIFO reports non-empty, it issues single-cycle pop strobes, waits for the acknowledge, and captures the popped word. It then presents the word on a valid/ready interface and holds it until the consumer accepts it. It sits between the FIFO pop bus and the serial TX path, so the CPU only pushes.

---
 rtl/fifo_ctrl_pkg.sv | 22 ++
 rtl/fifo_drain_ctrl_cycle_timer.sv | 35 +++
 rtl/fifo_drain_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO drain sequencer: state encodings,
// default ack timeout and the width of the delivered-word counter.
package fifo_ctrl_pkg;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_POP       = 3'd1;
    localparam logic [2:0] S_WAIT_ACK  = 3'd2;
    localparam logic [2:0] S_WAIT_DATA = 3'd3;
    localparam logic [2:0] S_PRESENT   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE      = S_IDLE,
        ST_POP       = S_POP,
        ST_WAIT_ACK  = S_WAIT_ACK,
        ST_WAIT_DATA = S_WAIT_DATA,
        ST_PRESENT   = S_PRESENT
    } state_t;

    localparam int ACK_TIMEOUT_DEF = 7;
    localparam int CNT_W           = 16;

endpackage

// File: rtl/fifo_drain_ctrl_cycle_timer.sv
// Loadable up/down counter with a flag that is high when the count equals
// a caller-supplied terminal value.
module cycle_timer #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_clear,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_up,
    input  logic         i_down,
    input  logic [W-1:0] i_term,
    output logic         o_hit
);

    logic [W-1:0] count;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            count <= '0;
        end else if (i_clear) begin
            count <= '0;
        end else if (i_load) begin
            count <= i_load_val;
        end else if (i_up) begin
            count <= count + 1'b1;
        end else if (i_down) begin
            count <= count - 1'b1;
        end
    end

    assign o_hit = (count == i_term);

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Drains a Wishbone FIFO pop port into a valid/ready byte consumer: pop,
// wait for ack, wait DATA_LAT cycles, capture, then hold until accepted.
module fifo_drain_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int DW          = 8,
    parameter int DATA_LAT    = 1,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_enable,
    input  logic             i_fifo_empty,
    output logic             o_fifo_pop_stb,
    output logic             o_fifo_pop_cyc,
    input  logic             i_fifo_pop_ack,
    input  logic [DW-1:0]    i_fifo_pop_data,
    output logic [DW-1:0]    o_tx_data,
    output logic             o_tx_valid,
    input  logic             i_tx_ready,
    output logic             o_busy,
    output logic             o_err_timeout,
    output logic [CNT_W-1:0] o_sent_count
);

    localparam int TW = 8;

    state_t           state, state_nx;
    logic             tmr_clear, tmr_load, tmr_up, tmr_down, tmr_hit;
    logic [TW-1:0]    tmr_term;
    logic             capture, timeout, accept;
    logic             err_q;
    logic [DW-1:0]    data_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state  <= ST_IDLE;
            err_q  <= 1'b0;
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            state <= state_nx;
            err_q <= timeout;
            if (capture) begin
                data_q <= i_fifo_pop_data;
            end
            if (accept) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // One timer serves both phases: it counts up from 0 while waiting for
    // the ack and counts down from DATA_LAT while waiting for the data.
    always_comb begin
        state_nx  = state;
        tmr_clear = 1'b0;
        tmr_load  = 1'b0;
        tmr_up    = 1'b0;
        tmr_down  = 1'b0;
        tmr_term  = TW'(ACK_TIMEOUT - 1);
        capture   = 1'b0;
        timeout   = 1'b0;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_enable && !i_fifo_empty) begin
                    state_nx = ST_POP;
                end
            end
            ST_POP: begin
                tmr_clear = 1'b1;
                state_nx  = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (i_fifo_pop_ack) begin
                    if (DATA_LAT == 0) begin
                        capture  = 1'b1;
                        state_nx = ST_PRESENT;
                    end else begin
                        tmr_load = 1'b1;
                        state_nx = ST_WAIT_DATA;
                    end
                end else if (tmr_hit) begin
                    timeout  = 1'b1;
                    state_nx = ST_IDLE;
                end else begin
                    tmr_up = 1'b1;
                end
            end
            ST_WAIT_DATA: begin
                tmr_term = TW'(1);
                if (tmr_hit) begin
                    capture  = 1'b1;
                    state_nx = ST_PRESENT;
                end else begin
                    tmr_down = 1'b1;
                end
            end
            ST_PRESENT: begin
                if (i_tx_ready) begin
                    accept   = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    cycle_timer #(
        .W (TW)
    ) u_timer (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_clear    (tmr_clear),
        .i_load     (tmr_load),
        .i_load_val (TW'(DATA_LAT)),
        .i_up       (tmr_up),
        .i_down     (tmr_down),
        .i_term     (tmr_term),
        .o_hit      (tmr_hit)
    );

    assign o_fifo_pop_stb = (state == ST_POP);
    assign o_fifo_pop_cyc = (state == ST_POP);
    assign o_tx_valid     = (state == ST_PRESENT);
    assign o_busy         = (state != ST_IDLE);
    assign o_err_timeout  = err_q;
    assign o_tx_data      = data_q;
    assign o_sent_count   = cnt_q;

endmodule
